// File: rtl/dmem_pkg.sv
// Shared encodings and the load lane-extract helper for the data memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
      SZ_HALF: r = {{16{h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// RD_LAT-stage response shift register; data stages only advance with a valid so the
// output data holds its last value between responses.
module dmem_rsp_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] data_i,
  input  logic        err_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic        err_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] err_q;
  logic [31:0]       dat_q [RD_LAT];

  // shift valid/err every cycle, data only behind a valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= 32'h0000_0000;
    end else begin
      vld_q[0] <= valid_i;
      err_q[0] <= valid_i & err_i;
      if (valid_i) dat_q[0] <= data_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[RD_LAT-1];
  assign err_o   = err_q[RD_LAT-1];
  assign data_o  = dat_q[RD_LAT-1];

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: byte/half/word loads and stores, self-clearing after reset.
// Optional DMEM_MISALIGN_EN flags misaligned/reserved accesses instead of forcing alignment.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             ready_q;

  logic [IDX_W-1:0] idx_s;
  logic [1:0]       eff_size_s;
  logic [1:0]       eff_lane_s;
  logic             err_s;
  logic             accept_s;
  logic [31:0]      cur_word_s;
  logic [31:0]      wr_word_s;
  logic [31:0]      ld_data_s;
  logic             pipe_err_s;
  logic             unused_addr_s;

  assign idx_s         = req_addr[IDX_W+1:2];
  assign unused_addr_s = ^req_addr[ADDR_W-1:IDX_W+2];
  assign accept_s      = req_valid & ready_q;
  assign cur_word_s    = mem_q[idx_s];

  // access decode: size/lane after alignment policy, plus error flag
  always_comb begin
    eff_size_s = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
`ifdef DMEM_MISALIGN_EN
    err_s = (req_size == SZ_RSVD) ||
            ((req_size == SZ_HALF) && req_addr[0]) ||
            ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    err_s = 1'b0;
`endif
    case (eff_size_s)
      SZ_BYTE: eff_lane_s = req_addr[1:0];
      SZ_HALF: eff_lane_s = {req_addr[1], 1'b0};
      default: eff_lane_s = 2'b00;
    endcase
  end

  // merge store data into the addressed lanes, keep the rest
  always_comb begin
    wr_word_s = cur_word_s;
    case (eff_size_s)
      SZ_BYTE: wr_word_s[{eff_lane_s, 3'b000} +: 8]      = req_wdata[7:0];
      SZ_HALF: wr_word_s[{eff_lane_s[1], 4'b0000} +: 16] = req_wdata[15:0];
      default: wr_word_s = req_wdata;
    endcase
  end

  assign ld_data_s = (req_we || err_s) ? 32'h0000_0000
                   : lane_extend(cur_word_s, eff_size_s, eff_lane_s, req_unsigned);

  // storage: cleared one word per cycle during INIT, written by accepted stores in RUN
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[clr_cnt_q] <= 32'h0000_0000;
    end else if (accept_s && req_we && !err_s) begin
      mem_q[idx_s] <= wr_word_s;
    end
  end

  // FSM next state: INIT walks every word once, RUN is terminal until reset
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_INIT: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
        else                                state_d = ST_INIT;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // FSM and ready registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= (state_d == ST_RUN);
    end
  end

  assign req_ready = ready_q;
  assign init_done = ready_q;

  dmem_rsp_pipe #(.RD_LAT(RD_LAT)) u_rsp_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (accept_s),
    .data_i  (ld_data_s),
    .err_i   (err_s),
    .valid_o (rsp_valid),
    .data_o  (rsp_rdata),
    .err_o   (pipe_err_s)
  );

`ifdef DMEM_MISALIGN_EN
  assign rsp_err = pipe_err_s;
`else
  assign rsp_err = 1'b0 & pipe_err_s;
`endif

endmodule
